// File: rtl/data_memory_pkg.sv
// Shared types and constants for the image data memory vector load/store paths.
package data_memory_pkg;

    localparam int DEF_IMAGE_WIDTH  = 96;
    localparam int DEF_IMAGE_HEIGHT = 96;
    localparam int DEF_PIX_SIZE     = 8;
    localparam int MAX_LANES        = 16;
    localparam int MEM_DEPTH        = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } dmw_state_t;

    typedef logic [MAX_LANES-1:0][15:0] vec16x16_t;

endpackage

// File: rtl/pixel_pack.sv
// 16-bit lane to pixel converter: unsigned clamp when DMW_SATURATE_EN is defined,
// plain truncation otherwise.
module pixel_pack #(
    parameter int PIX_SIZE = 8
) (
    input  logic [15:0]         din_i,
    output logic [PIX_SIZE-1:0] dout_o
);

`ifdef DMW_SATURATE_EN
    localparam logic [15:0] PIX_MAX = 16'((32'd1 << PIX_SIZE) - 32'd1);

    // Clamp values above the pixel range to full scale.
    always_comb begin
        if (din_i > PIX_MAX) begin
            dout_o = {PIX_SIZE{1'b1}};
        end else begin
            dout_o = din_i[PIX_SIZE-1:0];
        end
    end
`else
    logic unused_hi_s;
    assign unused_hi_s = ^din_i[15:PIX_SIZE];

    // Keep the low pixel bits only.
    always_comb begin
        dout_o = din_i[PIX_SIZE-1:0];
    end
`endif

endmodule

// File: rtl/data_memory_writer.sv
// Vector store engine: serializes the low lanes of a vector register into the
// byte-wide image memory, one pixel per clock. Pixel packing depends on DMW_SATURATE_EN.
module data_memory_writer
    import data_memory_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int PIX_SIZE     = DEF_PIX_SIZE,
    parameter int LANES        = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [15:0]          Addr,
    input  logic [15:0][15:0]    WD,
    input  logic [LANES-1:0]     lane_mask,
    output logic                 mem_we,
    output logic [15:0]          mem_addr,
    output logic [PIX_SIZE-1:0]  mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 oob
);

    localparam int unsigned DEPTH    = int'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [3:0]  LAST_IDX = 4'(LANES - 1);

    dmw_state_t            state_q;
    logic [3:0]            idx_q;
    logic [15:0]           base_q;
    vec16x16_t             wd_q;
    logic [15:0]           mask_q;
    logic                  req_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mem_we_q;
    logic [15:0]           mem_addr_q;
    logic [PIX_SIZE-1:0]   mem_wdata_q;
    logic                  oob_q;

    logic [15:0]           lane_addr_d;
    logic                  lane_in_range_d;
    logic [PIX_SIZE-1:0]   lane_pix_d;

    // The lane address wraps at 16 bits; wrapped addresses are judged like any other.
    assign lane_addr_d     = base_q + {12'd0, idx_q};
    assign lane_in_range_d = ({16'd0, lane_addr_d} < DEPTH);

    pixel_pack #(
        .PIX_SIZE (PIX_SIZE)
    ) u_pixel_pack (
        .din_i  (wd_q[idx_q]),
        .dout_o (lane_pix_d)
    );

    // Store FSM; outputs are registered, so each lane appears one cycle after its idx.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            base_q      <= 16'd0;
            wd_q        <= '0;
            mask_q      <= 16'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= '0;
            oob_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        state_q     <= WRITE;
                        base_q      <= Addr;
                        wd_q        <= WD;
                        mask_q      <= 16'(lane_mask);
                        idx_q       <= 4'd0;
                        oob_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_we_q    <= mask_q[idx_q] & lane_in_range_d;
                    mem_addr_q  <= lane_addr_d;
                    mem_wdata_q <= lane_pix_d;
                    if (mask_q[idx_q] && !lane_in_range_d) begin
                        oob_q <= 1'b1;
                    end else begin
                        oob_q <= oob_q;
                    end
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                DONE: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_we_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign oob       = oob_q;

endmodule

// File: tb/tb_data_memory_writer.sv
// Scoreboard bench for data_memory_writer: directed stores push expected writes and
// done pulses; a negedge monitor pops and compares them with cycle-accurate timing.
module tb_data_memory_writer;
    import data_memory_pkg::*;

    localparam int LANES = 8;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [15:0]      Addr = 16'd0;
    vec16x16_t        WD = '0;
    logic [7:0]       lane_mask = 8'd0;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic             busy;
    logic             done;
    logic             oob;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    wr_t  exp_q[$];
    int   done_q[$];
    wr_t  mon_e;
    int   mon_d;

    data_memory_writer #(
        .IMAGE_WIDTH  (96),
        .IMAGE_HEIGHT (96),
        .PIX_SIZE     (8),
        .LANES        (LANES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .Addr      (Addr),
        .WD        (WD),
        .lane_mask (lane_mask),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .oob       (oob)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int c, input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Holds req_valid with the given payload until a handshake edge; acc is the cycle count after it.
    task automatic send(input logic [15:0] a, input vec16x16_t w, input logic [7:0] m, output int acc);
        logic rdy;
        acc       = -1;
        req_valid = 1'b1;
        Addr      = a;
        WD        = w;
        lane_mask = m;
        for (int t = 0; t < 40 && acc < 0; t++) begin
            @(negedge CLK);
            rdy = req_ready;
            @(posedge CLK);
            #1;
            if (rdy === 1'b1) acc = cyc;
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no acceptance in 40 cycles, expected acceptance");
            acc = cyc;
        end
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: every write and done pulse must match the next expected entry.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h at cycle %0d, expected no write",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_cycle", cyc, mon_e.cyc);
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, mon_e.addr});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, mon_e.data});
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_cycle", cyc, mon_d);
                    chk("done_busy", {31'd0, busy}, 32'd0);
                    chk("done_ready", {31'd0, req_ready}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec16x16_t w, w2;
        int a, a2;

        idle_wait(2);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_oob", {31'd0, oob}, 32'd0);
        RST    = 1'b0;
        mon_en = 1'b1;

        // Basic store: 0x01..0x08 to 0x0010..0x0017
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = 16'(k + 1);
        send(16'h0010, w, 8'hFF, a);
        req_valid = 1'b0;
        for (int k = 0; k < LANES; k++) push_wr(a + 1 + k, 16'(16'h0010 + k), 8'(k + 1));
        done_q.push_back(a + 9);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        chk("basic_ready_low", {31'd0, req_ready}, 32'd0);
        idle_wait(12);
        chk("basic_oob", {31'd0, oob}, 32'd0);
        chk("basic_ready_back", {31'd0, req_ready}, 32'd1);

        // Mask 0xA5: lanes 0, 2, 5, 7 only
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = 16'(16'h0030 + k);
        send(16'h0100, w, 8'hA5, a);
        req_valid = 1'b0;
        push_wr(a + 1, 16'h0100, 8'h30);
        push_wr(a + 3, 16'h0102, 8'h32);
        push_wr(a + 6, 16'h0105, 8'h35);
        push_wr(a + 8, 16'h0107, 8'h37);
        done_q.push_back(a + 9);
        idle_wait(12);
        chk("mask_oob", {31'd0, oob}, 32'd0);

        // Bounds: 9212..9215 written, lanes 4..7 suppressed
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = 16'(16'h0040 + k);
        send(16'd9212, w, 8'hFF, a);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) push_wr(a + 1 + k, 16'(16'd9212 + k), 8'(8'h40 + k));
        done_q.push_back(a + 9);
        idle_wait(12);
        chk("bounds_oob", {31'd0, oob}, 32'd1);
        idle_wait(5);
        chk("bounds_oob_sticky", {31'd0, oob}, 32'd1);

        // Pack: 0x01FF -> 0xFF both builds; 0x0123 -> 0xFF saturated / 0x23 truncated
        w = '0;
        w[0] = 16'h01FF;
        w[1] = 16'h0123;
        send(16'h0200, w, 8'h03, a);
        req_valid = 1'b0;
        chk("oob_clear_on_accept", {31'd0, oob}, 32'd0);
        push_wr(a + 1, 16'h0200, 8'hFF);
`ifdef DMW_SATURATE_EN
        push_wr(a + 2, 16'h0201, 8'hFF);
`else
        push_wr(a + 2, 16'h0201, 8'h23);
`endif
        done_q.push_back(a + 9);
        idle_wait(12);

        // Wrap: base 0xFFFE, lanes 0/1 out of range, lanes 2..7 land at 0x0000..0x0005
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = 16'(16'h0050 + k);
        send(16'hFFFE, w, 8'hFF, a);
        req_valid = 1'b0;
        for (int k = 2; k < LANES; k++) push_wr(a + 1 + k, 16'(k - 2), 8'(8'h50 + k));
        done_q.push_back(a + 9);
        idle_wait(12);
        chk("wrap_oob", {31'd0, oob}, 32'd1);

        // Reset after lane 3: no further writes, no done
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = 16'(16'h0060 + k);
        send(16'h0300, w, 8'hFF, a);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) push_wr(a + 1 + k, 16'(16'h0300 + k), 8'(8'h60 + k));
        idle_wait(4);
        RST = 1'b1;
        idle_wait(1);
        RST = 1'b0;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        idle_wait(12);

        // New request after reset behaves normally
        w = '0;
        for (int k = 0; k < LANES; k++) w[k] = 16'(16'h0070 + k);
        send(16'h0400, w, 8'h0F, a);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) push_wr(a + 1 + k, 16'(16'h0400 + k), 8'(8'h70 + k));
        done_q.push_back(a + 9);
        idle_wait(12);

        // Back-to-back with req_valid held; payload switches right after the first handshake
        w  = '0;
        w2 = '0;
        for (int k = 0; k < LANES; k++) begin
            w[k]  = 16'(16'h0080 + k);
            w2[k] = 16'(16'h0090 + k);
        end
        send(16'h0500, w, 8'hFF, a);
        Addr = 16'h0600;
        WD   = w2;
        for (int k = 0; k < LANES; k++) push_wr(a + 1 + k, 16'(16'h0500 + k), 8'(8'h80 + k));
        done_q.push_back(a + 9);
        send(16'h0600, w2, 8'hFF, a2);
        req_valid = 1'b0;
        for (int k = 0; k < LANES; k++) push_wr(a2 + 1 + k, 16'(16'h0600 + k), 8'(8'h90 + k));
        done_q.push_back(a2 + 9);
        // ready returns after edge N+2+LANES, so the next handshake edge is N+3+LANES
        chk("b2b_interval", a2 - a, LANES + 3);
        idle_wait(14);

        chk("writes_drained", exp_q.size(), 32'd0);
        chk("dones_drained", done_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
